icu_sequencer: RTL and testbench

ICU_SEQUENCER -- requirements
Module: icu_sequencer

---
 rtl/icu_sequencer.sv | 143 ++++++++++++++
 tb/tb_icu_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icu_sequencer.sv
// icu_sequencer: two-cycle fetch/execute sequencer that feeds an ICU from a
// synchronous program ROM. It keeps a program counter and a small
// return-address stack, and it has a HALT state that is left on a resume pulse.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_FETCH | prog_addr = pc; the ROM word is read; advance when run is high
//   ST_EXEC  | ROM word is issued (instr_valid); ICU strobes select next pc
//   ST_HALT  | issue stopped, pc held; resume returns to ST_FETCH
module icu_sequencer #(
   parameter int ADDR_WIDTH  = 12,
   parameter int STACK_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  resume,
   output logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [ADDR_WIDTH+3:0] prog_data,
   output logic                  instr_valid,
   output logic [3:0]            instr,
   output logic [ADDR_WIDTH-1:0] operand,
   input  logic                  icu_jmp,
   input  logic                  icu_rtn,
   input  logic                  icu_flag_o,
   input  logic                  icu_flag_f,
   output logic                  user_flag,
   output logic                  halted,
   output logic                  stk_ovf,
   output logic                  stk_unf
);

   localparam int SP_W = $clog2(STACK_DEPTH);
   localparam logic [SP_W:0]       DEPTH_FULL = (SP_W+1)'(STACK_DEPTH);
   localparam logic [SP_W:0]       DEPTH_ONE  = (SP_W+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
   logic [SP_W:0]         depth;
   logic [3:0]            instr_q;
   logic [ADDR_WIDTH-1:0] operand_q;

   logic [3:0]            rom_op;
   logic [ADDR_WIDTH-1:0] rom_opnd;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic                  stk_full;
   logic                  stk_empty;
   logic [SP_W-1:0]       push_idx;
   logic [SP_W-1:0]       top_idx;
   logic                  in_exec;

   // ROM word split, wrapped pc increment and stack pointers
   always_comb begin
      rom_op    = prog_data[ADDR_WIDTH+3:ADDR_WIDTH];
      rom_opnd  = prog_data[ADDR_WIDTH-1:0];
      pc_inc    = pc + PC_ONE;
      stk_full  = (depth == DEPTH_FULL);
      stk_empty = (depth == '0);
      // Power-of-two depth: the low bits of depth address the next free slot,
      // and low bits minus one address the top entry (also correct when full).
      push_idx  = depth[SP_W-1:0];
      top_idx   = depth[SP_W-1:0] - SP_W'(1);
      in_exec   = (state == ST_EXEC);
   end

   // Issue outputs: the ROM word is presented live in EXEC so the ICU can
   // answer within the same cycle; otherwise the last issued word is held.
   always_comb begin
      prog_addr   = pc;
      instr_valid = in_exec;
      halted      = (state == ST_HALT);
      instr       = in_exec ? rom_op   : instr_q;
      operand     = in_exec ? rom_opnd : operand_q;
   end

   // Sequencer FSM: state, pc, return stack, sticky errors and user flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_FETCH;
         pc        <= '0;
         depth     <= '0;
         instr_q   <= '0;
         operand_q <= '0;
         user_flag <= 1'b0;
         stk_ovf   <= 1'b0;
         stk_unf   <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_mem[i] <= '0;
         end
      end else begin
         user_flag <= 1'b0;
         case (state)
            ST_FETCH: begin
               if (run) begin
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               instr_q   <= rom_op;
               operand_q <= rom_opnd;
               user_flag <= icu_flag_o;
               if (icu_jmp) begin
                  // Jump is always taken; a push into a full stack is dropped.
                  pc <= rom_opnd;
                  if (stk_full) begin
                     stk_ovf <= 1'b1;
                  end else begin
                     stack_mem[push_idx] <= pc_inc;
                     depth               <= depth + DEPTH_ONE;
                  end
               end else if (icu_rtn) begin
                  // Return from an empty stack degrades to a sequential step.
                  if (stk_empty) begin
                     pc      <= pc_inc;
                     stk_unf <= 1'b1;
                  end else begin
                     pc    <= stack_mem[top_idx];
                     depth <= depth - DEPTH_ONE;
                  end
               end else begin
                  pc <= pc_inc;
               end
               state <= icu_flag_f ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
               if (resume) begin
                  state <= ST_FETCH;
               end
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_icu_sequencer.sv
// Bench for icu_sequencer: behavioural sync ROM plus a small ICU decoder
// (op 1 jmp, 2 rtn, 3 jmp+rtn, 4 halt, 5 user flag). Expected issues are
// queued per program and popped by a monitor on every instr_valid.
module tb_icu_sequencer;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          run;
   logic          resume;
   logic [AW-1:0] prog_addr;
   logic [AW+3:0] prog_data = '0;
   logic          instr_valid;
   logic [3:0]    instr;
   logic [AW-1:0] operand;
   logic          icu_jmp, icu_rtn, icu_flag_o, icu_flag_f;
   logic          user_flag, halted, stk_ovf, stk_unf;
   logic          noise;

   logic [AW+3:0] rom [0:4095];

   typedef struct {
      logic [AW-1:0] addr;
      logic [3:0]    op;
      logic [AW-1:0] opnd;
   } issue_t;
   issue_t sb[$];

   typedef struct {
      logic [AW-1:0] addr;
      logic [3:0]    op;
      logic [AW-1:0] opnd;
      logic [AW-1:0] nxt;
      logic          uf;
      logic          hlt;
   } vec_t;
   vec_t tv [10];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) prog_data <= rom[prog_addr];

   // ICU model: strobes decoded from the issued opcode; noise drives all
   // strobes outside issue cycles, which the sequencer must ignore.
   assign icu_jmp    = (instr_valid && (instr == 4'd1 || instr == 4'd3)) || noise;
   assign icu_rtn    = (instr_valid && (instr == 4'd2 || instr == 4'd3)) || noise;
   assign icu_flag_f = (instr_valid && instr == 4'd4) || noise;
   assign icu_flag_o = (instr_valid && instr == 4'd5) || noise;

   icu_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .resume     (resume),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .instr_valid(instr_valid),
      .instr      (instr),
      .operand    (operand),
      .icu_jmp    (icu_jmp),
      .icu_rtn    (icu_rtn),
      .icu_flag_o (icu_flag_o),
      .icu_flag_f (icu_flag_f),
      .user_flag  (user_flag),
      .halted     (halted),
      .stk_ovf    (stk_ovf),
      .stk_unf    (stk_unf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every issued instruction must match the head of the scoreboard
   always @(negedge clk) begin
      if (!reset && instr_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got addr %0h op %0h expected no issue", prog_addr, instr);
         end else begin
            issue_t e;
            e = sb.pop_front();
            chk("issue_addr", 32'(prog_addr), 32'(e.addr));
            chk("issue_op", 32'(instr), 32'(e.op));
            chk("issue_operand", 32'(operand), 32'(e.opnd));
         end
      end
   end

   task automatic clear_rom();
      for (int i = 0; i < 4096; i++) rom[i] = '0;
   endtask

   task automatic put(input logic [AW-1:0] a, input logic [3:0] op, input logic [AW-1:0] opnd, input bit exp_issue);
      issue_t e;
      rom[a] = {op, opnd};
      if (exp_issue) begin
         e.addr = a; e.op = op; e.opnd = opnd;
         sb.push_back(e);
      end
   endtask

   task automatic expect_issue(input logic [AW-1:0] a, input logic [3:0] op, input logic [AW-1:0] opnd);
      issue_t e;
      e.addr = a; e.op = op; e.opnd = opnd;
      sb.push_back(e);
   endtask

   task automatic wait_valid(output int cnt);
      bit ok;
      ok = 1'b0;
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         cnt++;
         if (instr_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("issue_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_halt();
      bit ok;
      ok = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (halted) begin
            ok = 1'b1;
            break;
         end
      end
      chk("halt_reached", 32'(ok), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      tv[0] = '{12'h000, 4'd0, 12'h011, 12'h001, 1'b0, 1'b0};
      tv[1] = '{12'h001, 4'd5, 12'h022, 12'h002, 1'b1, 1'b0};
      tv[2] = '{12'h002, 4'd0, 12'h033, 12'h003, 1'b0, 1'b0};
      tv[3] = '{12'h003, 4'd0, 12'h044, 12'h004, 1'b0, 1'b0};
      tv[4] = '{12'h004, 4'd0, 12'h055, 12'h005, 1'b0, 1'b0};
      tv[5] = '{12'h005, 4'd1, 12'h100, 12'h100, 1'b0, 1'b0};
      tv[6] = '{12'h100, 4'd0, 12'h066, 12'h101, 1'b0, 1'b0};
      tv[7] = '{12'h101, 4'd2, 12'h077, 12'h006, 1'b0, 1'b0};
      tv[8] = '{12'h006, 4'd5, 12'h0AB, 12'h007, 1'b1, 1'b0};
      tv[9] = '{12'h007, 4'd4, 12'h000, 12'h008, 1'b0, 1'b1};

      reset = 1'b1; run = 1'b0; resume = 1'b0; noise = 1'b0;
      clear_rom();
      for (int i = 0; i < 10; i++) put(tv[i].addr, tv[i].op, tv[i].opnd, 1'b1);

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_prog_addr", 32'(prog_addr), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_operand", 32'(operand), 32'd0);
      chk("rst_user_flag", 32'(user_flag), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_stk_ovf", 32'(stk_ovf), 32'd0);
      chk("rst_stk_unf", 32'(stk_unf), 32'd0);

      // run low: hold in FETCH; stray strobes and resume are ignored
      reset = 1'b0; noise = 1'b1; resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      repeat (3) @(negedge clk);
      chk("hold_prog_addr", 32'(prog_addr), 32'd0);
      chk("hold_valid", 32'(instr_valid), 32'd0);
      chk("hold_halted", 32'(halted), 32'd0);
      chk("hold_ovf", 32'(stk_ovf), 32'd0);
      noise = 1'b0; run = 1'b1;

      // Table: linear run, call/return, user flag, halt
      for (int i = 0; i < 10; i++) begin
         wait_valid(cnt);
         chk("issue_latency", 32'(cnt), 32'd1);
         @(negedge clk);
         chk("next_addr", 32'(prog_addr), 32'(tv[i].nxt));
         chk("user_flag", 32'(user_flag), 32'(tv[i].uf));
         chk("halted", 32'(halted), 32'(tv[i].hlt));
         chk("valid_low", 32'(instr_valid), 32'd0);
         chk("instr_hold", 32'(instr), 32'(tv[i].op));
         chk("operand_hold", 32'(operand), 32'(tv[i].opnd));
      end

      // HALT holds pc for 10 cycles with no issue, even with stray strobes
      noise = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("halt_addr", 32'(prog_addr), 32'h008);
         chk("halt_valid", 32'(instr_valid), 32'd0);
         chk("halt_flag", 32'(halted), 32'd1);
      end
      noise = 1'b0;
      expect_issue(12'h008, 4'd0, 12'h000);
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      chk("resume_halted", 32'(halted), 32'd0);
      chk("resume_fetch", 32'(instr_valid), 32'd0);
      @(negedge clk);
      chk("resume_exec", 32'(instr_valid), 32'd1);
      chk("resume_addr", 32'(prog_addr), 32'h008);
      run = 1'b0;
      @(negedge clk);
      chk("stop_addr", 32'(prog_addr), 32'h009);
      chk("sb_empty_a", 32'(sb.size()), 32'd0);

      // Overflow / underflow with depth 4
      reset = 1'b1; run = 1'b0;
      clear_rom();
      sb.delete();
      put(12'h000, 4'd1, 12'h010, 1'b1);
      put(12'h010, 4'd1, 12'h020, 1'b1);
      put(12'h020, 4'd1, 12'h030, 1'b1);
      put(12'h030, 4'd1, 12'h040, 1'b1);
      put(12'h040, 4'd1, 12'h050, 1'b1);
      put(12'h050, 4'd2, 12'h000, 1'b1);
      put(12'h031, 4'd2, 12'h000, 1'b1);
      put(12'h021, 4'd2, 12'h000, 1'b1);
      put(12'h011, 4'd2, 12'h000, 1'b1);
      put(12'h001, 4'd2, 12'h000, 1'b1);
      put(12'h002, 4'd4, 12'h000, 1'b1);
      @(negedge clk);
      reset = 1'b0; run = 1'b1;
      wait_halt();
      chk("ovf_set", 32'(stk_ovf), 32'd1);
      chk("unf_set", 32'(stk_unf), 32'd1);
      chk("ovf_halt_addr", 32'(prog_addr), 32'h003);
      chk("sb_empty_b", 32'(sb.size()), 32'd0);
      // Sticky flags survive further execution
      expect_issue(12'h003, 4'd0, 12'h000);
      expect_issue(12'h004, 4'd0, 12'h000);
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      chk("ovf_sticky", 32'(stk_ovf), 32'd1);
      chk("unf_sticky", 32'(stk_unf), 32'd1);
      chk("sb_empty_b2", 32'(sb.size()), 32'd0);

      // Wrap at top of address space; jmp+rtn together pushes only
      reset = 1'b1;
      clear_rom();
      sb.delete();
      put(12'h000, 4'd2, 12'h000, 1'b1);
      put(12'h001, 4'd1, 12'hFFE, 1'b1);
      put(12'hFFE, 4'd3, 12'h020, 1'b1);
      put(12'h020, 4'd2, 12'h000, 1'b1);
      put(12'hFFF, 4'd0, 12'h000, 1'b1);
      expect_issue(12'h000, 4'd2, 12'h000);
      put(12'h002, 4'd4, 12'h000, 1'b1);
      @(negedge clk);
      chk("rst_clears_ovf", 32'(stk_ovf), 32'd0);
      chk("rst_clears_unf", 32'(stk_unf), 32'd0);
      reset = 1'b0; run = 1'b1;
      wait_halt();
      chk("wrap_unf", 32'(stk_unf), 32'd1);
      chk("wrap_ovf", 32'(stk_ovf), 32'd0);
      chk("wrap_halt_addr", 32'(prog_addr), 32'h003);
      chk("sb_empty_c", 32'(sb.size()), 32'd0);

      // Reset during EXEC at 0x30 with two return addresses stacked
      reset = 1'b1; run = 1'b0;
      clear_rom();
      sb.delete();
      put(12'h000, 4'd1, 12'h010, 1'b1);
      put(12'h010, 4'd1, 12'h030, 1'b1);
      put(12'h030, 4'd5, 12'h0AA, 1'b1);
      @(negedge clk);
      reset = 1'b0; run = 1'b1;
      begin
         bit hit;
         hit = 1'b0;
         repeat (50) begin
            @(negedge clk);
            if (instr_valid && prog_addr == 12'h030) begin
               hit = 1'b1;
               break;
            end
         end
         chk("reach_exec_30", 32'(hit), 32'd1);
      end
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_prog_addr", 32'(prog_addr), 32'd0);
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_instr", 32'(instr), 32'd0);
      chk("mid_rst_operand", 32'(operand), 32'd0);
      chk("mid_rst_halted", 32'(halted), 32'd0);
      chk("mid_rst_user_flag", 32'(user_flag), 32'd0);
      rom[0] = {4'd2, 12'h000};
      rom[1] = {4'd4, 12'h000};
      expect_issue(12'h000, 4'd2, 12'h000);
      expect_issue(12'h001, 4'd4, 12'h000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      wait_valid(cnt);
      chk("post_rst_latency", 32'(cnt), 32'd1);
      chk("post_rst_addr", 32'(prog_addr), 32'd0);
      wait_halt();
      chk("post_rst_unf", 32'(stk_unf), 32'd1);
      chk("post_rst_halt_addr", 32'(prog_addr), 32'h002);
      chk("sb_empty_d", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
